mult_div_controller: RTL and testbench

- Sequences the shared iterative multiply/divide resource for the R-type MULT and DIV instructions.
- The main multicycle control unit pulses start and then holds in a wait state until done.
- The block computes signed 64-bit products and signed quotient/remainder over 32 iteration cycles.
- It drives the HI/LO registers and flags divide-by-zero so the control unit can branch to its zerodiv exception state.

---
 rtl/mult_div_controller.sv | 170 +++++++++++++++++
 tb/tb_mult_div_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_controller.sv
// mult_div_controller
//   Sequences the shared iterative multiply/divide unit for MULT and DIV.
//   Signed 2*WIDTH-bit product, or signed quotient/remainder, computed on
//   operand magnitudes over WIDTH iteration cycles, then sign-corrected into
//   the HI/LO registers. DIV by zero is flagged without touching HI/LO.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   op         0 = MULT, 1 = DIV
//   a, b       two's complement operands (rs, rt)
//   busy       high whenever the unit is not idle
//   done       one-cycle completion pulse
//   div_zero   pulse with done when DIV had b == 0
//   hilo_write pulse with done when hi/lo were updated
//   hi, lo     product[2W-1:W]/product[W-1:0] or remainder/quotient
module mult_div_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             hilo_write,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               sa;
    logic               sb;
    logic               op_r;
    logic               err;
    // MULT: {partial product, remaining multiplier bits}
    // DIV : low half shifts dividend bits out and quotient bits in
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     madd;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        abs_a    = a[WIDTH-1] ? -a : a;
        abs_b    = b[WIDTH-1] ? -b : b;
        madd     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
        // Partial remainder plus next dividend bit; the extra top bit
        // of diff is the borrow that decides restore vs. keep.
        shifted  = {rem, acc[WIDTH-1]};
        diff     = shifted - {1'b0, mag_b};
        prod_fix = (sa ^ sb) ? -acc : acc;
        quo_fix  = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sa ? -rem : rem;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            sa         <= 1'b0;
            sb         <= 1'b0;
            op_r       <= 1'b0;
            err        <= 1'b0;
            acc        <= '0;
            rem        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            hilo_write <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            done       <= 1'b0;
            div_zero   <= 1'b0;
            hilo_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        sa    <= a[WIDTH-1];
                        sb    <= b[WIDTH-1];
                        op_r  <= op;
                        cnt   <= '0;
                        rem   <= '0;
                        acc   <= {{WIDTH{1'b0}}, (op ? abs_a : abs_b)};
                        err   <= op && (b == '0);
                        busy  <= 1'b1;
                        if (!op) begin
                            state <= MULT;
                        end else if (b != '0) begin
                            state <= DIV;
                        end else begin
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    if (acc[0]) begin
                        acc <= {madd, acc[WIDTH-1:1]};
                    end else begin
                        acc <= {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) state <= FIX;
                end
                DIV: begin
                    if (diff[WIDTH]) begin
                        rem <= shifted[WIDTH-1:0];
                    end else begin
                        rem <= diff[WIDTH-1:0];
                    end
                    acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH]};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) state <= FIX;
                end
                FIX: begin
                    if (op_r) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    state      <= DONE;
                    done       <= 1'b1;
                    hilo_write <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_controller.sv
module tb_mult_div_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        hilo_write;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests;
    int fails;
    int n;
    int busy_cnt;

    mult_div_controller #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hilo_write (hilo_write),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request across one rising edge (edge 0); afterwards the
    // operands are scrambled to show they are not needed any more.
    task automatic start_op(input logic o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hDEADBEEF;
        b     = 32'h0BADF00D;
    endtask

    // Waits (bounded) for done, counting edges after edge 0 and busy samples.
    task automatic wait_done();
        n        = 0;
        busy_cnt = 0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) busy_cnt++;
    endtask

    task automatic run(input string tag, input logic o, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] ehi, input logic [31:0] elo);
        start_op(o, va, vb);
        wait_done();
        check({tag, " latency"}, n, 33);
        check({tag, " done"}, done, 1);
        check({tag, " hilo_write"}, hilo_write, 1);
        check({tag, " div_zero"}, div_zero, 0);
        check({tag, " hi"}, hi, ehi);
        check({tag, " lo"}, lo, elo);
        @(posedge clk);
        #1;
        check({tag, " done drop"}, done, 0);
        check({tag, " busy drop"}, busy, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        @(negedge clk);
        reset = 1'b1;

        // 7 * -3 with busy-duration check
        start_op(1'b0, 32'd7, 32'hFFFFFFFD);
        wait_done();
        check("mul7x-3 latency", n, 33);
        check("mul7x-3 busy cycles", busy_cnt, 34);
        check("mul7x-3 hilo_write", hilo_write, 1);
        check("mul7x-3 hi", hi, 32'hFFFFFFFF);
        check("mul7x-3 lo", lo, 32'hFFFFFFEB);
        @(posedge clk);
        #1;
        check("mul7x-3 done pulse", done, 0);
        check("mul7x-3 hilo pulse", hilo_write, 0);
        check("mul7x-3 busy fall", busy, 0);

        run("mul_maxpos", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);
        run("mul_minneg", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run("div-7/2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div7/-2",    1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run("div100/7",   1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
        run("div-100/7",  1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2);
        run("div_wrap",   1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run("mul3x5",     1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F);

        // divide by zero: error path right after edge 0, hi/lo retained
        start_op(1'b1, 32'd5, 32'd0);
        check("dz done", done, 1);
        check("dz div_zero", div_zero, 1);
        check("dz hilo_write", hilo_write, 0);
        check("dz busy", busy, 1);
        check("dz hi", hi, 0);
        check("dz lo", lo, 15);
        @(posedge clk);
        #1;
        check("dz done drop", done, 0);
        check("dz div_zero drop", div_zero, 0);
        check("dz busy drop", busy, 0);
        check("dz lo held", lo, 15);

        // start during iteration and during DONE is ignored
        start_op(1'b0, 32'h00001234, 32'h00000100);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd9;
        b     = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign no div_zero", div_zero, 0);
        check("ign busy", busy, 1);
        wait_done();
        check("ign latency", n, 27);
        check("ign hi", hi, 32'h00000000);
        check("ign lo", lo, 32'h00123400);
        start = 1'b1;
        op    = 1'b1;
        b     = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign done-state busy", busy, 0);
        check("ign done-state dz", div_zero, 0);
        check("ign done-state done", done, 0);

        // asynchronous reset mid-operation
        start_op(1'b0, 32'h00000011, 32'h00000022);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst busy", busy, 0);
        check("arst hi", hi, 0);
        check("arst lo", lo, 0);
        check("arst done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        run("mul2x3", 1'b0, 32'd2, 32'd3, 32'h00000000, 32'h00000006);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
